// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the single async_fifo write port among NREQ requesters.
// Write-clock domain only; a grant ends on the packet's last beat or after MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  input  logic [NREQ*WIDTH-1:0] i_req_data,
  input  logic [NREQ-1:0]       i_req_last,
  output logic [NREQ-1:0]       o_req_ready,
  output logic [WIDTH-1:0]      o_fifo_wdata,
  output logic                  o_fifo_wen,
  input  logic                  i_fifo_full,
  output logic [NREQ-1:0]       o_grant,
  output logic [15:0]           o_stall_cnt
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, owner, sel_idx;
  logic            sel_found;
  logic [7:0]      beat_cnt, beat_inc;
  logic            owner_valid, owner_last, xfer, burst_done, release_now;

  assign owner_valid = i_req_valid[owner];
  assign owner_last  = i_req_last[owner];
  assign xfer        = (state == GRANT) && owner_valid && !i_fifo_full;
  assign beat_inc    = beat_cnt + 8'd1;
  assign burst_done  = (beat_inc == 8'(MAX_BURST));
  assign release_now = xfer && (owner_last || burst_done);

  // First valid requester at or above the pointer, wrapping modulo NREQ.
  always_comb begin
    int j;
    sel_found = 1'b0;
    sel_idx   = ptr;
    j         = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!sel_found && i_req_valid[IW'(j)]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(j);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found)   state_nxt = GRANT;
      GRANT:   if (release_now) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the state test, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    o_fifo_wen   = 1'b0;
    o_req_ready  = '0;
    o_fifo_wdata = '0;
    if (state == GRANT) begin
      o_fifo_wen         = xfer;
      o_req_ready[owner] = xfer;
      o_fifo_wdata       = i_req_data[owner*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr      <= '0;
      owner    <= '0;
      beat_cnt <= '0;
      o_grant  <= '0;
    end else if (state == IDLE) begin
      if (sel_found) begin
        owner    <= sel_idx;
        o_grant  <= NREQ'(1) << sel_idx;
        beat_cnt <= '0;
      end
    end else if (xfer) begin
      beat_cnt <= beat_inc;
      if (release_now) begin
        o_grant <= '0;
        ptr     <= (owner == IW'(NREQ-1)) ? '0 : owner + 1'b1;
      end
    end
  end

  // Counts cycles where the owner has data but the FIFO cannot take it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cnt <= '0;
    end else if (state == GRANT && owner_valid && i_fifo_full && o_stall_cnt != 16'hFFFF) begin
      o_stall_cnt <= o_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed requester traffic, expected writes
// queued in hand-computed order and compared by an independent monitor.
module tb_fifo_wr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  i_clk = 1'b0;
  logic                  i_rst_n;
  logic [NREQ-1:0]       i_req_valid;
  logic [NREQ*WIDTH-1:0] i_req_data;
  logic [NREQ-1:0]       i_req_last;
  logic [NREQ-1:0]       o_req_ready;
  logic [WIDTH-1:0]      o_fifo_wdata;
  logic                  o_fifo_wen;
  logic                  i_fifo_full;
  logic [NREQ-1:0]       o_grant;
  logic [15:0]           o_stall_cnt;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .i_req_data   (i_req_data),
    .i_req_last   (i_req_last),
    .o_req_ready  (o_req_ready),
    .o_fifo_wdata (o_fifo_wdata),
    .o_fifo_wen   (o_fifo_wen),
    .i_fifo_full  (i_fifo_full),
    .o_grant      (o_grant),
    .o_stall_cnt  (o_stall_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [7:0] d; logic l; } beat_t;
  typedef struct { logic [3:0] g; logic [7:0] d; } exp_t;

  beat_t           src [NREQ][$];
  exp_t            exp_q[$];
  int              wr_cyc[$];
  int              cyc = 0;
  int              n_checks = 0;
  int              n_errors = 0;
  logic [NREQ-1:0] pause = '0;
  logic [NREQ-1:0] accepted;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    src[k].push_back(b);
  endtask

  task automatic expect_wr(input logic [3:0] g, input logic [7:0] d);
    exp_t e;
    e.g = g;
    e.d = d;
    exp_q.push_back(e);
  endtask

  function automatic bit busy();
    bit b = (exp_q.size() != 0);
    for (int k = 0; k < NREQ; k++) if (src[k].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      @(posedge i_clk);
      n++;
    end
    check(name, {31'd0, busy()}, 32'd0);
    repeat (3) @(posedge i_clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #2;
    i_rst_n     = 1'b0;
    i_fifo_full = 1'b0;
    pause       = '0;
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    wr_cyc.delete();
  endtask

  // Requester model: holds each beat until it sees ready, then advances.
  initial begin
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    accepted    = '0;
    forever begin
      @(negedge i_clk);
      for (int k = 0; k < NREQ; k++)
        if (accepted[k] && src[k].size() != 0) src[k].delete(0);
      for (int k = 0; k < NREQ; k++) begin
        if (src[k].size() != 0 && !pause[k]) begin
          i_req_valid[k]               = 1'b1;
          i_req_data[k*WIDTH +: WIDTH] = src[k][0].d;
          i_req_last[k]                = src[k][0].l;
        end else begin
          i_req_valid[k]               = 1'b0;
          i_req_data[k*WIDTH +: WIDTH] = '0;
          i_req_last[k]                = 1'b0;
        end
      end
      #1 accepted = o_req_ready;
    end
  end

  // Monitor: invariants every cycle, scoreboard pop on every write.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      #3;
      if (i_rst_n) begin
        check("wen_while_full", {31'd0, o_fifo_wen & i_fifo_full}, 32'd0);
        check("grant_onehot0", {31'd0, $onehot0(o_grant)}, 32'd1);
        check("ready_vs_grant", {28'd0, o_req_ready}, o_fifo_wen ? {28'd0, o_grant} : 32'd0);
        if (o_fifo_wen) begin
          wr_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got grant=%b data=%h, required no write", o_grant, o_fifo_wdata);
          end else begin
            e = exp_q.pop_front();
            check("wr_grant", {28'd0, o_grant}, {28'd0, e.g});
            check("wr_data", {24'd0, o_fifo_wdata}, {24'd0, e.d});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    int n;
    bit found;
    i_rst_n     = 1'b0;
    i_fifo_full = 1'b0;
    #3;
    check("rst_grant", {28'd0, o_grant}, 32'd0);
    check("rst_ready", {28'd0, o_req_ready}, 32'd0);
    check("rst_wen", {31'd0, o_fifo_wen}, 32'd0);
    check("rst_wdata", {24'd0, o_fifo_wdata}, 32'd0);
    check("rst_stall", {16'd0, o_stall_cnt}, 32'd0);
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;

    // Single requester, 3-beat packet.
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    expect_wr(4'b0001, 8'h11); expect_wr(4'b0001, 8'h22); expect_wr(4'b0001, 8'h33);
    wr_cyc.delete();
    @(posedge i_clk);
    #1;
    check("t1_grant_latency", {28'd0, o_grant}, 32'd1);
    drain("t1_drain", 50);
    check("t1_nwrites", wr_cyc.size(), 3);
    if (wr_cyc.size() == 3) begin
      check("t1_gap01", wr_cyc[1] - wr_cyc[0], 1);
      check("t1_gap12", wr_cyc[2] - wr_cyc[1], 1);
    end

    // Pointer now 1: req1 wins over req0.
    push(0, 8'hA0, 1'b1); push(1, 8'hA1, 1'b1);
    expect_wr(4'b0010, 8'hA1); expect_wr(4'b0001, 8'hA0);
    drain("t1_ptr_drain", 50);

    // Round robin, 1-beat packets from all four.
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      push(k, 8'h40 + 8'(k), 1'b1);
      push(k, 8'h50 + 8'(k), 1'b1);
    end
    for (int k = 0; k < NREQ; k++) expect_wr(4'(1 << k), 8'h40 + 8'(k));
    for (int k = 0; k < NREQ; k++) expect_wr(4'(1 << k), 8'h50 + 8'(k));
    drain("rr_drain", 100);
    check("rr_nwrites", wr_cyc.size(), 8);
    if (wr_cyc.size() == 8)
      for (int i = 1; i < 8; i++) check("rr_gap", wr_cyc[i] - wr_cyc[i-1], 2);

    // Burst limit: req2 6 beats, req3 interleaves after 4.
    do_reset();
    for (int i = 0; i < 6; i++) push(2, 8'h60 + 8'(i), (i == 5));
    push(3, 8'h70, 1'b1);
    for (int i = 0; i < 4; i++) expect_wr(4'b0100, 8'h60 + 8'(i));
    expect_wr(4'b1000, 8'h70);
    expect_wr(4'b0100, 8'h64); expect_wr(4'b0100, 8'h65);
    drain("burst_drain", 100);
    check("burst_nwrites", wr_cyc.size(), 7);
    if (wr_cyc.size() == 7) begin
      check("burst_gap_to_req3", wr_cyc[4] - wr_cyc[3], 2);
      check("burst_gap_to_req2", wr_cyc[5] - wr_cyc[4], 2);
    end

    // Full stall while req1 owns the port.
    do_reset();
    i_fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) push(1, 8'h81 + 8'(i), (i == 3));
    for (int i = 0; i < 4; i++) expect_wr(4'b0010, 8'h81 + 8'(i));
    @(posedge i_clk);
    #1;
    check("full_grant", {28'd0, o_grant}, 32'd2);
    repeat (5) begin
      @(negedge i_clk);
      #3;
      check("full_wen", {31'd0, o_fifo_wen}, 32'd0);
      check("full_ready", {28'd0, o_req_ready}, 32'd0);
    end
    @(posedge i_clk);
    #1;
    check("full_stall_cnt", {16'd0, o_stall_cnt}, 32'd5);
    #1 i_fifo_full = 1'b0;
    #1 check("full_resume_wen", {31'd0, o_fifo_wen}, 32'd1);
    drain("full_drain", 50);
    check("full_stall_final", {16'd0, o_stall_cnt}, 32'd5);

    // Async reset during beat 2; pointer must restart from 0.
    do_reset();
    push(1, 8'h88, 1'b1);
    expect_wr(4'b0010, 8'h88);
    drain("ar_pre_drain", 50);
    for (int i = 0; i < 4; i++) push(2, 8'h91 + 8'(i), (i == 3));
    expect_wr(4'b0100, 8'h91);
    n = 0;
    found = 1'b0;
    while (!found && n < 50) begin
      @(negedge i_clk);
      #2;
      n++;
      found = o_fifo_wen && (o_fifo_wdata == 8'h92);
    end
    check("ar_reach_beat2", {31'd0, found}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    check("ar_grant", {28'd0, o_grant}, 32'd0);
    check("ar_wen", {31'd0, o_fifo_wen}, 32'd0);
    check("ar_ready", {28'd0, o_req_ready}, 32'd0);
    check("ar_wdata", {24'd0, o_fifo_wdata}, 32'd0);
    check("ar_beat1_written", exp_q.size(), 0);
    for (int k = 0; k < NREQ; k++) src[k].delete();
    repeat (2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b1;
    push(3, 8'hB3, 1'b1); push(1, 8'hB1, 1'b1);
    expect_wr(4'b0010, 8'hB1); expect_wr(4'b1000, 8'hB3);
    drain("ar_post_drain", 50);

    // Owner pauses mid-packet while req1 waits.
    do_reset();
    push(0, 8'hC1, 1'b0); push(0, 8'hC2, 1'b0); push(0, 8'hC3, 1'b1);
    push(1, 8'hD1, 1'b1);
    expect_wr(4'b0001, 8'hC1); expect_wr(4'b0001, 8'hC2); expect_wr(4'b0001, 8'hC3);
    expect_wr(4'b0010, 8'hD1);
    n = 0;
    while (wr_cyc.size() < 1 && n < 50) begin
      @(posedge i_clk);
      #2;
      n++;
    end
    check("pause_first_write", wr_cyc.size(), 1);
    pause[0] = 1'b1;
    repeat (5) begin
      @(negedge i_clk);
      #3;
      check("pause_grant_held", {28'd0, o_grant}, 32'd1);
      check("pause_no_write", {31'd0, o_fifo_wen}, 32'd0);
    end
    @(posedge i_clk);
    #2;
    pause[0] = 1'b0;
    drain("pause_drain", 50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of async_fifo among NREQ requesters.
- Sits entirely in the FIFO write-clock domain. Drives the FIFO write data and write enable, and observes the FIFO full flag.
- Grants one requester at a time. A grant lasts until that requester's packet ends or the burst limit is hit, whichever comes first.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width; must match the FIFO WIDTH.
- MAX_BURST, 4, maximum beats per grant (1..255).

Ports:
- i_clk  in  1  write-side clock (same clock as the FIFO write clock).
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_req_valid  in  NREQ  per-requester data valid.
- i_req_data  in  NREQ*WIDTH  per-requester data; requester k occupies bits [k*WIDTH +: WIDTH].
- i_req_last  in  NREQ  marks the final beat of a packet.
- o_req_ready  out  NREQ  per-requester accept; at most one bit set.
- o_fifo_wdata  out  WIDTH  to the FIFO write-data input.
- o_fifo_wen  out  1  to the FIFO write-enable input.
- i_fifo_full  in  1  from the FIFO full flag.
- o_grant  out  NREQ  one-hot current owner; 0 when idle.
- o_stall_cnt  out  16  saturating count of owner-valid-while-full cycles.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low (i_rst_n).
- Reset values:
  - state = IDLE; priority pointer = 0; beat counter = 0.
  - o_grant = 0; o_stall_cnt = 0.
  - o_req_ready = 0; o_fifo_wen = 0; o_fifo_wdata = 0.
- State IDLE:
  - o_req_ready = 0, o_fifo_wen = 0, o_fifo_wdata = 0.
  - If any i_req_valid bit is set, select the first valid index searching upward from the pointer, wrapping modulo NREQ.
  - Register the selection into o_grant and go to GRANT. Beat counter clears to 0.
  - Arbitration latency: 1 cycle from valid to grant.
- State GRANT, owner k:
  - o_fifo_wdata = i_req_data[k] (combinational).
  - o_fifo_wen = o_req_ready[k] = i_req_valid[k] & ~i_fifo_full (combinational).
  - All other ready bits are 0.
- Transfer: a cycle with o_fifo_wen = 1. The beat counter increments on each transfer.
- Release: a transfer with i_req_last[k] = 1, or a transfer that makes the beat count equal MAX_BURST.
  - On release: next state = IDLE, pointer = (k+1) mod NREQ, o_grant = 0.
  - There is always one idle cycle between consecutive grants.
- Owner drops valid mid-packet: the grant is held indefinitely. There is no timeout and no other requester is served.
- FIFO full: no write is issued; the grant is held.
  - o_stall_cnt increments in any GRANT cycle with i_req_valid[k] & i_fifo_full. It saturates at 0xFFFF.
- Burst limit hit without last: the grant is released mid-packet. Other requesters may then interleave beats into the FIFO.
  - Packet integrity is guaranteed only for packets of at most MAX_BURST beats.
- Invariants:
  - o_fifo_wen is never asserted while i_fifo_full = 1.
  - o_grant is always zero or one-hot.
- Reset asserted mid-grant: all state returns immediately (asynchronously) to the reset values. Any partially sent packet is abandoned.
- Non-owner requesters: valid and data are ignored. They must hold their beat until they see ready.

Test Plan:
- Single requester: req0 sends 3 beats (0x11, 0x22, 0x33) with last on the third; FIFO not full.
  - Required: o_grant = 0001 one cycle after valid. Three consecutive o_fifo_wen pulses carry 0x11, 0x22, 0x33. Then IDLE with pointer = 1.
- Round-robin: all 4 requesters continuously valid, each sending 1-beat packets.
  - Required: grant order 0, 1, 2, 3, 0, 1. Exactly one write every 2 cycles.
- Burst limit: MAX_BURST = 4; req2 sends a 6-beat packet while req3 is also valid.
  - Required: 4 beats from req2, 1 idle cycle, then req3 granted. req2 is re-granted later and finishes its remaining 2 beats.
- Full stall: fill the FIFO to full (16 entries) while req1 is valid and granted.
  - Required: o_fifo_wen = 0 and o_req_ready = 0 while full; o_stall_cnt counts those cycles. Writing resumes on the first cycle full deasserts. Data read out of the FIFO is in order with no duplicates or drops.
- Async reset mid-packet: deassert i_rst_n between clock edges during beat 2 of a 4-beat packet.
  - Required: outputs go to reset values without waiting for a clock edge. After release, arbitration restarts from pointer 0.
- Owner pause: the owner deasserts valid for 5 cycles mid-packet while another requester is valid.
  - Required: the grant is held throughout, no writes occur, and the packet resumes and completes before any other grant.
